// File: rtl/cc_match_resolver.sv
// Candy board match resolver: repeatedly detects runs of >=3, clears them
// (stripes widen the clear), applies one-row-per-cycle gravity, and reports the score.
module cc_match_resolver #(
  parameter int unsigned MAX_ROUNDS = 16,
  parameter logic [2:0]  EMPTY      = 3'd7
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_start,
  input  logic [107:0] in_board,
  input  logic [35:0]  in_stripe_en,
  input  logic [35:0]  in_stripe_dir,
  output logic         busy,
  output logic         out_valid,
  output logic [6:0]   out_score,
  output logic         out_overflow
);

  localparam int RW = $clog2(MAX_ROUNDS + 1);

  typedef enum logic [2:0] {S_IDLE, S_DETECT, S_STRIPE, S_CLEAR, S_GRAVITY, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [35:0][2:0]   board_q, board_d;
  logic [35:0]        sen_q, sen_d, sdir_q, sdir_d, mark_q, mark_d;
  logic [RW-1:0]      round_q, round_d;
  logic [6:0]         score_q, score_d;
  logic               ovf_q, ovf_d, busy_q, busy_d, valid_q, valid_d;

  logic [35:0]        det_mark, stripe_mark;
  logic [35:0][2:0]   grav_board;
  logic [35:0]        grav_en, grav_dir;
  logic               moved;
  logic [5:0]         pop;
  logic [7:0]         score_sum;
  logic [6:0]         score_sat;

  // Every 3-wide window of one colour marks its cells; overlapping windows cover longer runs.
  always_comb begin
    det_mark = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 4; c++)
        if (board_q[r*6+c] != EMPTY && board_q[r*6+c] == board_q[r*6+c+1] &&
            board_q[r*6+c] == board_q[r*6+c+2]) begin
          det_mark[r*6+c]   = 1'b1;
          det_mark[r*6+c+1] = 1'b1;
          det_mark[r*6+c+2] = 1'b1;
        end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 6; c++)
        if (board_q[r*6+c] != EMPTY && board_q[r*6+c] == board_q[(r+1)*6+c] &&
            board_q[r*6+c] == board_q[(r+2)*6+c]) begin
          det_mark[r*6+c]     = 1'b1;
          det_mark[(r+1)*6+c] = 1'b1;
          det_mark[(r+2)*6+c] = 1'b1;
        end
  end

  // Only marks from detection trigger stripes; cells a stripe adds never chain.
  always_comb begin
    stripe_mark = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        if (mark_q[r*6+c] && sen_q[r*6+c])
          for (int k = 0; k < 6; k++) begin
            if (!sdir_q[r*6+c]) begin
              if (board_q[r*6+k] != EMPTY) stripe_mark[r*6+k] = 1'b1;
            end else begin
              if (board_q[k*6+c] != EMPTY) stripe_mark[k*6+c] = 1'b1;
            end
          end
  end

  // One gravity step, evaluated against the current board only.
  always_comb begin
    grav_board = board_q;
    grav_en    = sen_q;
    grav_dir   = sdir_q;
    moved      = 1'b0;
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 6; c++)
        if (board_q[r*6+c] != EMPTY && board_q[(r+1)*6+c] == EMPTY) begin
          grav_board[(r+1)*6+c] = board_q[r*6+c];
          grav_en[(r+1)*6+c]    = sen_q[r*6+c];
          grav_dir[(r+1)*6+c]   = sdir_q[r*6+c];
          grav_board[r*6+c]     = EMPTY;
          grav_en[r*6+c]        = 1'b0;
          grav_dir[r*6+c]       = 1'b0;
          moved                 = 1'b1;
        end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < 36; i++) pop = pop + 6'(mark_q[i]);
    score_sum = {1'b0, score_q} + {2'b00, pop};
    score_sat = (score_sum > 8'd127) ? 7'd127 : score_sum[6:0];
  end

  always_comb begin
    state_d = state_q;
    board_d = board_q;
    sen_d   = sen_q;
    sdir_d  = sdir_q;
    mark_d  = mark_q;
    round_d = round_q;
    score_d = score_q;
    ovf_d   = ovf_q;
    busy_d  = busy_q;
    valid_d = 1'b0;
    case (state_q)
      S_IDLE: if (in_start) begin
        board_d = in_board;
        sen_d   = in_stripe_en;
        sdir_d  = in_stripe_dir;
        score_d = '0;
        ovf_d   = 1'b0;
        round_d = '0;
        busy_d  = 1'b1;
        state_d = S_DETECT;
      end
      S_DETECT: begin
        mark_d = det_mark;
        if (det_mark == '0 || round_q == RW'(MAX_ROUNDS)) begin
          ovf_d   = (det_mark != '0);
          valid_d = 1'b1;
          busy_d  = 1'b0;
          state_d = S_DONE;
        end else begin
          state_d = S_STRIPE;
        end
      end
      S_STRIPE: begin
        mark_d  = mark_q | stripe_mark;
        state_d = S_CLEAR;
      end
      S_CLEAR: begin
        for (int i = 0; i < 36; i++)
          if (mark_q[i]) begin
            board_d[i] = EMPTY;
            sen_d[i]   = 1'b0;
            sdir_d[i]  = 1'b0;
          end
        score_d = score_sat;
        round_d = round_q + RW'(1);
        state_d = S_GRAVITY;
      end
      S_GRAVITY: begin
        board_d = grav_board;
        sen_d   = grav_en;
        sdir_d  = grav_dir;
        if (!moved) state_d = S_DETECT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      board_q <= {36{EMPTY}};
      sen_q   <= '0;
      sdir_q  <= '0;
      mark_q  <= '0;
      round_q <= '0;
      score_q <= '0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      board_q <= board_d;
      sen_q   <= sen_d;
      sdir_q  <= sdir_d;
      mark_q  <= mark_d;
      round_q <= round_d;
      score_q <= score_d;
      ovf_q   <= ovf_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign busy         = busy_q;
  assign out_valid    = valid_q;
  assign out_score    = score_q;
  assign out_overflow = ovf_q;

endmodule
